m_mc_ctrl: RTL
==============

Name: m_mc_ctrl

Overview:
- Multi-cycle sequencer for the single-issue RV32 datapath: PC adder, asynchronous instruction memory, register-file read muxes, adder, and write-back register.
- Steps each instruction through IF, ID, EX and WB, one state per cycle.
- Stalls IF on an instruction-memory ready handshake.
- Emits per-stage register write enables, counts retired instructions, and traps on non-R-type opcodes.

Parameters:
- OPCODE_OP, 7'b0110011: the only legal opcode (R-type ALU op).
- CNT_W, 32: width of the retire counter and of the optional performance counters.

Ports:
- w_clk, input, 1: clock, rising edge.
- w_rst, input, 1: synchronous reset, active-high.
- w_run, input, 1: level; allows fetching to start or continue.
- w_halt_req, input, 1: pulse; request a stop at the next instruction boundary.
- w_imem_rdy, input, 1: instruction memory data valid this cycle.
- w_ir_op, input, 7: opcode field of the IR register (ir[6:0]).
- w_pc_we, output, 1: PC register load of PC+4.
- w_ir_we, output, 1: IR register load.
- w_opr_we, output, 1: load of operand registers r1/r2.
- w_rt_we, output, 1: load of the adder result register.
- w_rf_we, output, 1: register-file write (x1).
- w_state, output, 3: current state encoding.
- w_busy, output, 1: 1 when state is not IDLE and not HALT.
- w_illegal, output, 1: sticky illegal-opcode flag.
- w_retired, output, CNT_W: retired instruction count.
- w_cycles, output, CNT_W: busy-cycle count (optional feature).
- w_stalls, output, CNT_W: IF stall count (optional feature).

Behaviour:
- States and encodings: IDLE=0, IF=1, ID=2, EX=3, WB=4, HALT=5. Codes 6 and 7 go to HALT and set w_illegal.
- Reset (w_rst=1 at a rising edge): state=IDLE, halt_pend=0, w_illegal=0, all counters=0. All enables are 0 during and after reset.
- Reset wins over every other input in the same cycle. Reset mid-instruction aborts it with no rf write.
- IDLE: halt_pend cleared. If w_run=1, next state is IF.
- IF:
  - If w_imem_rdy=1: w_ir_we=1 and w_pc_we=1 in the same cycle (Mealy); next state is ID.
  - Otherwise stay in IF with both enables 0; each such cycle counts as a stall.
- ID: w_opr_we=1.
  - If w_ir_op equals OPCODE_OP, next state is EX.
  - Otherwise next state is HALT and w_illegal is set. Nothing is written to EX or RF.
- EX: w_rt_we=1; next state is WB.
- WB: w_rf_we=1 and w_retired increments by 1.
  - If halt_pend=1, or w_halt_req=1 this cycle, or w_run=0: next state is IDLE.
  - Otherwise next state is IF.
- HALT: all enables 0. The only exit is reset. w_illegal stays 1.
- Enables are Moore-decoded from the state, except w_ir_we and w_pc_we in IF. At most one stage-enable group is active per cycle.
- Halt handling: w_halt_req in any of IF, ID or EX sets halt_pend. The current instruction always completes through WB; there is never a partial retire.
- Latency: with w_imem_rdy held at 1, one instruction takes 4 cycles. From IDLE with w_run=1, the first w_rf_we occurs 4 cycles after leaving IDLE.
- Counters wrap modulo 2^CNT_W with no saturation and no flag.
- w_run dropping mid-instruction does not abort it. It is checked only in IDLE and at WB.

Optional Feature:
- Macro: MC_CTRL_PERF_EN.
- Defined:
  - w_cycles increments every cycle w_busy=1.
  - w_stalls increments every IF cycle with w_imem_rdy=0.
  - Both are cleared by reset and wrap at CNT_W.
- Undefined: both ports exist but are tied to 0, and no counter flops are built.

Decomposition:
- Package m_ctrl_pkg holds:
  - state encodings (S_IDLE..S_HALT, 3-bit);
  - OPCODE_OP default;
  - FUNCT3/FUNCT7 zero constants, for later decode extension.
- One sub-module, m_ctrl_cnt: CNT_W-bit counter with synchronous clear and increment enable.
  - Instantiated once for w_retired, and twice more under MC_CTRL_PERF_EN.

Test Plan:
- Nominal run: reset 2 cycles, then w_run=1, w_imem_rdy=1, ADD opcode. After 13 cycles: w_retired=3; w_state sequence 0,1,2,3,4,1,2,3,4,...; exactly 3 w_rf_we pulses.
- Stall: w_imem_rdy=0 for 3 cycles in the first IF. Required: state stays 1 for 4 cycles, no w_ir_we until rdy, w_stalls=3 (PERF_EN), w_retired=1 at cycle 8.
- Halt: w_halt_req pulse during EX of instruction 2. Required: WB completes, w_retired=2, state=0, w_busy=0. Re-asserting w_run restarts at IF.
- Illegal opcode: w_ir_op=7'b0010011 in ID. Required: next state=5, w_illegal=1, no w_rt_we/w_rf_we, w_retired unchanged. Held for 10 cycles regardless of w_run.
- Reset mid-op: w_rst=1 in EX. Required: next state=0, w_retired=0, w_illegal=0, no w_rf_we pulse.
- Wrap: CNT_W=4, 17 instructions. Required: w_retired=1.

Source files
------------

// File: rtl/m_ctrl_pkg.sv
// m_ctrl_pkg: shared state encodings and decode constants for the multi-cycle controller.
package m_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;
  localparam logic [6:0] OPCODE_OP_DFLT = 7'b0110011;
  localparam logic [2:0] FUNCT3_ADD = 3'b000;
  localparam logic [6:0] FUNCT7_ADD = 7'b0000000;
endpackage

// File: rtl/m_ctrl_cnt.sv
// m_ctrl_cnt: wrapping counter with synchronous clear and increment enable.
module m_ctrl_cnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_d, cnt_q;
  always_comb cnt_d = inc ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk) begin
    if (clr) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign cnt = cnt_q;
endmodule

// File: rtl/m_mc_ctrl.sv
// m_mc_ctrl: IF/ID/EX/WB sequencer with imem stall, halt-at-boundary and illegal-op trap.
// Define MC_CTRL_PERF_EN to build the busy-cycle and IF-stall counters.
module m_mc_ctrl
  import m_ctrl_pkg::*;
#(
  parameter logic [6:0]  OPCODE_OP = OPCODE_OP_DFLT,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             w_clk,
  input  logic             w_rst,
  input  logic             w_run,
  input  logic             w_halt_req,
  input  logic             w_imem_rdy,
  input  logic [6:0]       w_ir_op,
  output logic             w_pc_we,
  output logic             w_ir_we,
  output logic             w_opr_we,
  output logic             w_rt_we,
  output logic             w_rf_we,
  output logic [2:0]       w_state,
  output logic             w_busy,
  output logic             w_illegal,
  output logic [CNT_W-1:0] w_retired,
  output logic [CNT_W-1:0] w_cycles,
  output logic [CNT_W-1:0] w_stalls
);
  state_t state_d, state_q;
  logic halt_pend_d, halt_pend_q, illegal_d, illegal_q;
  logic fetch_we, opr_we, rt_we, rf_we;
  always_comb begin
    state_d     = state_q;
    halt_pend_d = halt_pend_q | w_halt_req;
    illegal_d   = illegal_q;
    fetch_we    = 1'b0;
    opr_we      = 1'b0;
    rt_we       = 1'b0;
    rf_we       = 1'b0;
    case (state_q)
      S_IDLE: begin
        halt_pend_d = 1'b0;
        state_d     = w_run ? S_IF : S_IDLE;
      end
      S_IF: begin
        fetch_we = w_imem_rdy;
        state_d  = w_imem_rdy ? S_ID : S_IF;
      end
      S_ID: begin
        opr_we    = 1'b1;
        state_d   = (w_ir_op == OPCODE_OP) ? S_EX : S_HALT;
        illegal_d = illegal_q | (w_ir_op != OPCODE_OP);
      end
      S_EX: begin
        rt_we   = 1'b1;
        state_d = S_WB;
      end
      S_WB: begin
        rf_we       = 1'b1;
        halt_pend_d = 1'b0;
        state_d     = (halt_pend_q | w_halt_req | ~w_run) ? S_IDLE : S_IF;
      end
      S_HALT: halt_pend_d = halt_pend_q;
      default: begin
        state_d   = S_HALT;
        illegal_d = 1'b1;
      end
    endcase
  end
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state_q     <= S_IDLE;
      halt_pend_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      halt_pend_q <= halt_pend_d;
      illegal_q   <= illegal_d;
    end
  end
  // Enables are masked while reset is asserted so an aborted instruction never writes.
  assign w_pc_we   = fetch_we & ~w_rst;
  assign w_ir_we   = fetch_we & ~w_rst;
  assign w_opr_we  = opr_we & ~w_rst;
  assign w_rt_we   = rt_we & ~w_rst;
  assign w_rf_we   = rf_we & ~w_rst;
  assign w_state   = state_q;
  assign w_busy    = (state_q != S_IDLE) && (state_q != S_HALT);
  assign w_illegal = illegal_q;
  m_ctrl_cnt #(.W(CNT_W)) u_ret (.clk(w_clk), .clr(w_rst), .inc(w_rf_we), .cnt(w_retired));
`ifdef MC_CTRL_PERF_EN
  m_ctrl_cnt #(.W(CNT_W)) u_cyc (.clk(w_clk), .clr(w_rst), .inc(w_busy), .cnt(w_cycles));
  m_ctrl_cnt #(.W(CNT_W)) u_stl (
    .clk(w_clk), .clr(w_rst), .inc((state_q == S_IF) & ~w_imem_rdy), .cnt(w_stalls)
  );
`else
  assign w_cycles = '0;
  assign w_stalls = '0;
`endif
endmodule
